// File: rtl/mem_access_unit.sv
// Memory-side responder for the multicycle CPU. It performs one word, half or byte
// access per request on a single-port synchronous memory. Sub-word stores use read-modify-write.
module mem_access_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SH  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_MERGE, S_WRITE, S_DONE
    } state_t;

    // The ADDR/WAIT sequencing assumes exactly one cycle of read latency.
    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("mem_access_unit: only RD_LAT == 1 is supported");
    end

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        misal;
    logic        sub_store_q;
    logic [NUM_LANES-1:0]            st_be;
    logic [NUM_LANES-1:0][VEC_W-1:0] st_rep;
    logic [NUM_LANES-1:0][VEC_W-1:0] merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign misal = (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) ||
                   (((op == OP_LH) || (op == OP_SH)) && addr[0]);

    assign sub_store_q = (op_q == OP_SH) || (op_q == OP_SB);

    always_comb begin
        st_be  = '0;
        st_rep = '0;
        if (op_q == OP_SB) begin
            st_be  = 4'b0001 << lane_q;
            st_rep = {4{wdata_q[7:0]}};
        end else begin
            st_be  = lane_q[1] ? 4'b1100 : 4'b0011;
            st_rep = {2{wdata_q}};
        end
    end

    // Replace only the enabled byte lanes of the word just read back.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign merged[k] = st_be[k] ? st_rep[k] : mem_rdata[VEC_W*k +: VEC_W];
    end

    always_comb begin
        ld_byte = mem_rdata[8*lane_q +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LW:   ld_ext = mem_rdata;
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            default: ld_ext = {24'h0, ld_byte};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q     <= op;
                        lane_q   <= addr[1:0];
                        wdata_q  <= wdata[15:0];
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (misal) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (op == OP_SW) begin
                            state     <= S_WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: state <= S_WAIT;
                S_WAIT: begin
                    if (sub_store_q) begin
                        state     <= S_MERGE;
                        mem_wdata <= merged;
                        mem_we    <= 1'b1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        rdata <= ld_ext;
                    end
                end
                S_MERGE, S_WRITE: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    misaligned <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses against a
// small word memory, plus hand sequences for ignored req and reset during a merge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misaligned, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .misaligned(misaligned), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous read-first memory with one cycle of read latency.
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request; returns cycles from accept edge to done (0 = timeout).
    task automatic do_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                             output int lat, output int wes, output bit busy_ok,
                             output logic mis, output logic [31:0] rd, output logic [31:0] ma);
        @(negedge clk);
        op = o; addr = a; wdata = w; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        lat = 0; wes = 0; busy_ok = 1'b1; mis = 1'b0; rd = '0; ma = '0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_we) wes++;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c; mis = misaligned; rd = rdata; ma = mem_addr;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] exp_rd;
        logic [31:0] exp_mem;
        logic        exp_mis;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t vt [17];

    initial begin
        int lat, wes, cnt;
        bit busy_ok;
        logic mis;
        logic [31:0] rd, ma, a;

        vt[0]  = '{3'd0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3, 0};
        vt[1]  = '{3'd2, 32'h13, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 32'h80FF7F01, 1'b0, 3, 0};
        vt[2]  = '{3'd6, 32'h13, 32'h0,        32'h80FF7F01, 32'h00000080, 32'h80FF7F01, 1'b0, 3, 0};
        vt[3]  = '{3'd1, 32'h12, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01, 1'b0, 3, 0};
        vt[4]  = '{3'd1, 32'h10, 32'h0,        32'h80FF7F01, 32'h00007F01, 32'h80FF7F01, 1'b0, 3, 0};
        vt[5]  = '{3'd2, 32'h11, 32'h0,        32'h80FF7F01, 32'h0000007F, 32'h80FF7F01, 1'b0, 3, 0};
        vt[6]  = '{3'd5, 32'h21, 32'h000000AB, 32'h11223344, 32'h0000007F, 32'h1122AB44, 1'b0, 4, 1};
        vt[7]  = '{3'd3, 32'h22, 32'h12345678, 32'h55667788, 32'h0000007F, 32'h55667788, 1'b1, 1, 0};
        vt[8]  = '{3'd1, 32'h11, 32'h0,        32'h80FF7F01, 32'h0000007F, 32'h80FF7F01, 1'b1, 1, 0};
        vt[9]  = '{3'd3, 32'h24, 32'hCAFEF00D, 32'h00000000, 32'h0000007F, 32'hCAFEF00D, 1'b0, 2, 1};
        vt[10] = '{3'd4, 32'h26, 32'h1234BEEF, 32'hAAAAAAAA, 32'h0000007F, 32'hBEEFAAAA, 1'b0, 4, 1};
        vt[11] = '{3'd4, 32'h28, 32'h00005678, 32'hFFFFFFFF, 32'h0000007F, 32'hFFFF5678, 1'b0, 4, 1};
        vt[12] = '{3'd5, 32'h2F, 32'h000000C3, 32'h00000000, 32'h0000007F, 32'hC3000000, 1'b0, 4, 1};
        vt[13] = '{3'd6, 32'hFD, 32'h0,        32'h8C9C7CAB, 32'h0000007C, 32'h8C9C7CAB, 1'b0, 3, 0};
        vt[14] = '{3'd7, 32'hFE, 32'h0,        32'h8C9C7CAB, 32'h0000009C, 32'h8C9C7CAB, 1'b0, 3, 0};
        vt[15] = '{3'd2, 32'hFC, 32'h0,        32'h8C9C7CAB, 32'hFFFFFFAB, 32'h8C9C7CAB, 1'b0, 3, 0};
        vt[16] = '{3'd0, 32'h23, 32'h0,        32'h00000000, 32'hFFFFFFAB, 32'h00000000, 1'b1, 1, 0};

        // Reset state
        #12;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            preload(vt[i].addr, vt[i].pre);
            do_access(vt[i].op, vt[i].addr, vt[i].wdata, lat, wes, busy_ok, mis, rd, ma);
            a = vt[i].addr;
            chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("v%0d_misaligned", i), {31'h0, mis}, {31'h0, vt[i].exp_mis});
            chk($sformatf("v%0d_we_count", i), wes, vt[i].exp_we);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_mem_word", i), mem[a[7:2]], vt[i].exp_mem);
            chk($sformatf("v%0d_mem_addr", i), ma, {a[31:2], 2'b00});
            chk($sformatf("v%0d_busy", i), {31'h0, busy_ok}, 32'h1);
        end

        // req held high through ADDR and WAIT must not start a second access.
        preload(32'hFC, 32'h8C9C7CAB);
        @(negedge clk);
        op = 3'd6; addr = 32'hFD; req = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) req = 1'b0;
            if (done) cnt++;
        end
        req = 1'b0;
        chk("midreq_done_count", cnt, 1);
        chk("midreq_rdata", rdata, 32'h0000007C);
        chk("midreq_idle", {31'h0, busy}, 32'h0);

        // Reset asserted while an sh is in MERGE.
        preload(32'h30, 32'h01020304);
        @(negedge clk);
        op = 3'd4; addr = 32'h32; wdata = 32'h00009999; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("merge_we_high", {31'h0, mem_we}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we", {31'h0, mem_we}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_mis", {31'h0, misaligned}, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_maddr", mem_addr, 32'h0);
        chk("arst_mwdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("arst_mem_kept", mem[12], 32'h01020304);
        do_access(3'd0, 32'h30, 32'h0, lat, wes, busy_ok, mis, rd, ma);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", rd, 32'h01020304);
        chk("post_rst_we", wes, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
